serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

- Parametrised, clocked, MSB-first magnitude comparator for two WIDTH-bit operands.
- Captures operands on a start handshake and examines one bit pair per cycle. It terminates early at the first differing bit and reports a registered one-hot less/equal/greater result with a done pulse.
- Supports unsigned and two's-complement comparison.
- An enable input freezes the scan for power gating. This lets many instances be tiled in a multi-bit comparator array with only the active lanes clocking through work.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH): width of the bit-index counter (derived, not overridden).

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  power-gating qualifier; when low, all state and outputs hold.
- start  input  1  request; sampled only in IDLE with enable high.
- signed_mode  input  1  captured with operands; 1 = two's-complement, 0 = unsigned.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when the result becomes valid.
- less_than  output  1  A < B.
- equal_to  output  1  A == B.
- greater_than  output  1  A > B.

## Operation
- Reset values: busy=0, done=0, {less_than, equal_to, greater_than}=3'b000, state=IDLE, index=WIDTH-1, operand registers=0.
- State machine (IDLE, SCAN):
  - **IDLE → SCAN**: on an edge with enable=1 and start=1.
    - Latch a, b and signed_mode.
    - Set index=WIDTH-1.
    - Clear the result to 3'b000.
  - **SCAN, a[index]==b[index]**:
    - If index>0: decrement index and stay in SCAN.
    - If index==0: set result 3'b010, pulse done, go to IDLE.
  - **SCAN, bits differ**: set the result from that bit, pulse done, go to IDLE. The bit is:
    - unsigned, or signed with index<WIDTH-1: greater_than=a_bit, less_than=b_bit.
    - signed with index==WIDTH-1 (sign bit): polarity is inverted, so greater_than=b_bit and less_than=a_bit.
- The result is always one-hot or all-zero, and is held until the next accepted start.
- **start while busy**: ignored, no queuing. Operands are not re-sampled.
- **start on the same edge as done**: legal back-to-back operation. The result clears on the following edge.
- **enable low**: freezes state, index, result and done.
  - A done that would have been generated is deferred to the first enabled cycle.
  - start is ignored while enable is low.
- **reset mid-SCAN**: return to IDLE with result 3'b000. No done pulse is produced.

## Timing
- Let the accepted start edge be E0, and let p = WIDTH-1-k, where k is the index of the highest differing bit.
- The result and done are valid after edge E(p+1), i.e. p+1 enabled cycles of latency.
- Equal operands take WIDTH enabled cycles; WIDTH is the worst case.
- busy is high from after E0 until the edge that asserts done; busy and done are never high together.
- Each cycle with enable low adds one cycle to the latency.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package comparator_pkg holds:
  - state enum cmp_state_t {IDLE, SCAN};
  - result constants RES_NONE=3'b000, RES_LT=3'b100, RES_EQ=3'b010, RES_GT=3'b001, ordered {less_than, equal_to, greater_than}.
- Sub-module comparator_bit_cell: purely combinational single-bit decision.
  - Inputs: a_bit, b_bit, invert.
  - Outputs: lt, eq, gt.
  - Instantiated once on the selected bit pair; invert = signed_mode & (index==WIDTH-1).
- The top level holds the FSM, index counter, operand registers and result register.

## Test plan
All scenarios use WIDTH=8.
- **Reset**: reset for 2 cycles with random inputs → busy=0, done=0, outputs 000. Then start, a=8'h3C, b=8'h3C (unsigned) → 010 with done after exactly 8 cycles.
- **Early exit**:
  - a=8'h80, b=8'h7F (unsigned) → greater_than=1, done after 1 cycle.
  - a=8'h04, b=8'h05 → less_than=1, done after 8 cycles.
- **Signed**: signed_mode=1, a=8'hFF (-1), b=8'h01 → less_than=1 after 1 cycle. signed_mode=1, a=8'hFE, b=8'hFF → less_than=1 after 8 cycles.
- **Gating**: a=8'h10, b=8'h00, enable held low for 3 cycles mid-scan → outputs frozen, greater_than=1 with done after 4+3=7 cycles. start pulsed while enable is low → ignored.
- **Handshake**:
  - start re-asserted with new operands while busy → first result unaffected.
  - start on the done edge → second operation begins, result reads 000 during its scan.
- **Reset mid-scan**: reset at cycle 3 of an equal-operand scan → IDLE, outputs 000, no done pulse. A following start operates normally.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types and constants for the serial magnitude comparator.
//   cmp_state_t  : scan FSM states (IDLE, SCAN)
//   cmp_result_t : result vector ordered {less_than, equal_to, greater_than}
//   RES_*        : the only legal result encodings (one-hot or all-zero)
//   pack_result  : builds a result vector from the three decision bits
// -----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cmp_state_t;

    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t RES_NONE = 3'b000;
    localparam cmp_result_t RES_LT   = 3'b100;
    localparam cmp_result_t RES_EQ   = 3'b010;
    localparam cmp_result_t RES_GT   = 3'b001;

    function automatic cmp_result_t pack_result(input logic lt, input logic eq, input logic gt);
        return {lt, eq, gt};
    endfunction

endpackage : comparator_pkg

// File: rtl/serial_magnitude_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator_if
// Request/result bundle for one comparator lane.
//   enable       : lane power-gating qualifier (master -> slave)
//   start        : request, sampled in IDLE with enable high (master -> slave)
//   signed_mode  : 1 = two's-complement, 0 = unsigned (master -> slave)
//   a, b         : WIDTH-bit operands (master -> slave)
//   busy         : scan in progress (slave -> master)
//   done         : one-cycle result-valid pulse (slave -> master)
//   less_than, equal_to, greater_than : registered result (slave -> master)
// -----------------------------------------------------------------------------
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             less_than;
    logic             equal_to;
    logic             greater_than;

    modport master (
        output enable, start, signed_mode, a, b,
        input  busy, done, less_than, equal_to, greater_than
    );

    modport slave (
        input  enable, start, signed_mode, a, b,
        output busy, done, less_than, equal_to, greater_than
    );

endinterface : serial_magnitude_comparator_if

// File: rtl/serial_magnitude_comparator_bit_cell.sv
// -----------------------------------------------------------------------------
// comparator_bit_cell
// Purely combinational decision for a single bit pair.
//   a_bit, b_bit : the bit pair under examination
//   invert       : 1 when the pair is the two's-complement sign bit, where a
//                  set bit means "more negative" and the polarity flips
//   lt, eq, gt   : decision for this bit; eq=1 means "keep scanning"
// -----------------------------------------------------------------------------
module comparator_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    output logic lt,
    output logic eq,
    output logic gt
);

    logic a_only;
    logic b_only;

    assign a_only = a_bit & ~b_bit;
    assign b_only = b_bit & ~a_bit;

    assign eq = (a_bit == b_bit);
    assign gt = invert ? b_only : a_only;
    assign lt = invert ? a_only : b_only;

endmodule : comparator_bit_cell

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
// MSB-first serial magnitude comparator. On an accepted start it captures both
// operands and the signedness, then examines one bit pair per enabled cycle,
// stopping at the first differing bit. The one-hot result is registered and
// held until the next accepted start; done pulses for one enabled cycle.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : serial_magnitude_comparator_if.slave (enable, start, signed_mode,
//            a, b in; busy, done, less_than, equal_to, greater_than out)
// With enable low every register holds, so a gated lane consumes no scan steps
// and a pending done simply appears on the first enabled cycle.
// -----------------------------------------------------------------------------
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_magnitude_comparator_if.slave  bus
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] TOP_INDEX = CNT_W'(WIDTH - 1);

    cmp_state_t       state_q,  state_d;
    logic [CNT_W-1:0] index_q,  index_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             signed_q, signed_d;
    cmp_result_t      result_q, result_d;
    logic             done_q,   done_d;

    logic cell_lt;
    logic cell_eq;
    logic cell_gt;
    logic cell_invert;

    // Only the sign bit of a signed compare flips the decision polarity.
    assign cell_invert = signed_q & (index_q == TOP_INDEX);

    comparator_bit_cell u_bit_cell (
        .a_bit  (a_q[index_q]),
        .b_bit  (b_q[index_q]),
        .invert (cell_invert),
        .lt     (cell_lt),
        .eq     (cell_eq),
        .gt     (cell_gt)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the value.
        state_d  = state_q;
        index_d  = index_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = bus.signed_mode;
                    index_d  = TOP_INDEX;
                    result_d = RES_NONE;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (!cell_eq) begin
                    // First differing bit from the top decides the whole compare.
                    result_d = pack_result(cell_lt, 1'b0, cell_gt);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (index_q == '0) begin
                    result_d = RES_EQ;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    index_d = index_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            index_q  <= TOP_INDEX;
            // NOTE: the operand registers are plain flops, not a memory array,
            // so resetting them is cheap and keeps the bit cell inputs defined.
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            result_q <= RES_NONE;
            done_q   <= 1'b0;
        end else if (bus.enable) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q  <= state_d;
            index_q  <= index_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy         = (state_q == SCAN);
    assign bus.done         = done_q;
    assign bus.less_than    = result_q[2];
    assign bus.equal_to     = result_q[1];
    assign bus.greater_than = result_q[0];

endmodule : serial_magnitude_comparator
